pot_dot_product_sequencer: RTL and testbench

Sequential controller that streams (activation, power-of-two weight) pairs through a power-of-two shift multiplier datapath and accumulates a signed dot product of programmable length. It sits between an operand-fetch front end (valid/ready stream) and a result consumer (valid/ready stream). It owns the job FSM, element counter, product pipeline register and accumulator.

---
 rtl/pot_dot_product_sequencer.sv | 131 +++++++++++++
 tb/tb_pot_dot_product_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/pot_dot_product_sequencer.sv
// pot_dot_product_sequencer
// Streams (activation, power-of-two weight) pairs through a shift multiplier,
// registers each product for one cycle, then accumulates a signed dot product
// of programmable length. The result is held on a valid/ready output until it
// is consumed.
module pot_dot_product_sequencer #(
    parameter int  WEIGHT_BIT_WIDTH = 4,
    parameter int  INPUT_BIT_WIDTH  = 4,
    parameter int  MAX_LEN          = 16,
    localparam int PROD_WIDTH       = INPUT_BIT_WIDTH + (2 ** WEIGHT_BIT_WIDTH) / 2,
    localparam int LEN_WIDTH        = $clog2(MAX_LEN + 1),
    localparam int ACC_WIDTH        = PROD_WIDTH + $clog2(MAX_LEN)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [LEN_WIDTH-1:0]        len,
    output logic                        busy,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [INPUT_BIT_WIDTH-1:0]  in_data,
    input  logic [WEIGHT_BIT_WIDTH-1:0] in_weight,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [ACC_WIDTH-1:0]        out_data
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_e;

    state_e                 state_q, state_d;
    logic [LEN_WIDTH-1:0]   remaining_q, remaining_d;
    logic                   prod_valid_q, prod_valid_d;
    logic [PROD_WIDTH-1:0]  prod_q, prod_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;

    logic [LEN_WIDTH-1:0]   len_clamped;
    logic [PROD_WIDTH-1:0]  prod_mag;
    logic [ACC_WIDTH-1:0]   prod_ext;
    logic                   in_fire;

    // Outputs are pure decodes of registered state, so in_ready never
    // depends on in_valid.
    assign in_ready  = (state_q == RUN) && (remaining_q != '0);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign out_data  = acc_q;
    assign in_fire   = in_valid && in_ready;

    // Shift multiplier: the exponent shifts the zero-extended activation, the
    // sign bit negates it (so sign=1, exponent=0 gives -in_data).
    always_comb begin
        len_clamped = (len > LEN_WIDTH'(MAX_LEN)) ? LEN_WIDTH'(MAX_LEN) : len;
        prod_mag    = {{(PROD_WIDTH - INPUT_BIT_WIDTH){1'b0}}, in_data}
                      << in_weight[WEIGHT_BIT_WIDTH-2:0];
        prod_ext    = ACC_WIDTH'($signed(prod_q));
    end

    // Next-state logic for the job FSM, element counter, product stage and
    // accumulator.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned; a missed branch would otherwise infer a latch.
        state_d      = state_q;
        remaining_d  = remaining_q;
        prod_valid_d = in_fire;
        prod_d       = prod_q;
        acc_d        = prod_valid_q ? (acc_q + prod_ext) : acc_q;

        if (in_fire) begin
            prod_d = in_weight[WEIGHT_BIT_WIDTH-1] ? -prod_mag : prod_mag;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d = '0;
                    if (len_clamped != '0) begin
                        remaining_d = len_clamped;
                        state_d     = RUN;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            RUN: begin
                if (in_fire) begin
                    remaining_d = remaining_q - LEN_WIDTH'(1);
                    if (remaining_q == LEN_WIDTH'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset aborts any job in flight and discards partial sums.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            remaining_q  <= '0;
            prod_valid_q <= 1'b0;
            prod_q       <= '0;
            acc_q        <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values regardless of statement order.
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            prod_valid_q <= prod_valid_d;
            prod_q       <= prod_d;
            acc_q        <= acc_d;
        end
    end

endmodule

// File: tb/tb_pot_dot_product_sequencer.sv
// Directed bench for pot_dot_product_sequencer with hand-computed results.
module tb_pot_dot_product_sequencer;

    localparam int W   = 4;
    localparam int IW  = 4;
    localparam int ML  = 16;
    localparam int LW  = 5;
    localparam int AW  = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [LW-1:0] len = '0;
    logic          busy;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [IW-1:0] in_data = '0;
    logic [W-1:0]  in_weight = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [AW-1:0] out_data;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int start_cyc = 0;
    int accepted = 0;
    int latency = 0;
    logic [AW-1:0] held;

    pot_dot_product_sequencer #(
        .WEIGHT_BIT_WIDTH(W),
        .INPUT_BIT_WIDTH (IW),
        .MAX_LEN         (ML)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .len      (len),
        .busy     (busy),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_weight(in_weight),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulses start for one cycle; returns one cycle after the sampling edge.
    task automatic start_job(input int n);
        in_valid  = 1'b0;
        start     = 1'b1;
        len       = LW'(n);
        start_cyc = cyc;
        accepted  = 0;
        tick();
        start = 1'b0;
    endtask

    // Offers one pair, optionally after an idle cycle, until it is accepted.
    task automatic send(input int d, input int wcode, input bit gap);
        bit done;
        done = 1'b0;
        if (gap) begin
            in_valid = 1'b0;
            tick();
            check("ready_in_gap", in_ready, 1);
        end
        in_valid  = 1'b1;
        in_data   = IW'(d);
        in_weight = W'(wcode);
        for (int i = 0; i < 20 && !done; i++) begin
            if (in_ready) begin
                done = 1'b1;
                accepted++;
            end
            tick();
        end
        in_valid = 1'b0;
        if (!done) check("send_timeout", 0, 1);
    endtask

    // Waits a bounded number of cycles for out_valid; records start latency.
    task automatic wait_out(input int max_cyc);
        for (int i = 0; i < max_cyc && !out_valid; i++) tick();
        latency = cyc - start_cyc;
        if (!out_valid) check("out_valid_timeout", 0, 1);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("post_hs_out_valid", out_valid, 0);
        check("post_hs_busy", busy, 0);
    endtask

    initial begin
        // Reset asserted mid-cycle while idle.
        #3 rst = 1'b1;
        #1;
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", $signed(out_data), 0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("idle_busy", busy, 0);
        check("idle_in_ready", in_ready, 0);

        // Basic job: 5<<2 - (3<<1) + (15<<7) = 20 - 6 + 1920.
        start_job(3);
        check("basic_busy", busy, 1);
        check("basic_in_ready", in_ready, 1);
        send(5, 4'b0010, 0);
        send(3, 4'b1001, 0);
        send(15, 4'b0111, 0);
        check("basic_drain_ready", in_ready, 0);
        wait_out(10);
        check("basic_latency", latency, 5);
        check("basic_sum", $signed(out_data), 1934);
        consume();

        // Largest negative products, then sign with zero exponent.
        start_job(2);
        send(15, 4'b1111, 0);
        send(15, 4'b1111, 0);
        wait_out(10);
        check("neg_sum", $signed(out_data), -3840);
        consume();
        start_job(1);
        send(7, 4'b1000, 0);
        wait_out(10);
        check("neg_zero_exp", $signed(out_data), -7);
        check("neg_zero_exp_lat", latency, 3);
        consume();

        // Stalled input: 1 + (2<<3) - (9<<2) + (4<<5) = 1 + 16 - 36 + 128.
        start_job(4);
        send(1, 4'b0000, 0);
        send(2, 4'b0011, 1);
        send(9, 4'b1010, 1);
        send(4, 4'b0101, 1);
        in_valid = 1'b1;
        in_data  = 4'd15;
        in_weight = 4'b0111;
        wait_out(10);
        check("stall_accepted", accepted, 4);
        check("stall_extra_ready", in_ready, 0);
        check("stall_sum", $signed(out_data), 109);
        in_valid = 1'b0;
        held = out_data;
        for (int i = 0; i < 5; i++) begin
            start = (i % 2 == 0);
            len   = 5'd2;
            tick();
            check("hold_valid", out_valid, 1);
            check("hold_data", $signed(out_data), $signed(held));
        end
        start = 1'b0;
        consume();
        tick();
        check("start_ignored_busy", busy, 0);

        // Zero length completes straight away with a cleared accumulator.
        start_job(0);
        check("len0_valid", out_valid, 1);
        check("len0_data", $signed(out_data), 0);
        check("len0_in_ready", in_ready, 0);
        consume();

        // Over-long length clamps to MAX_LEN: 16 * 1920.
        start_job(ML + 3);
        for (int i = 0; i < ML; i++) send(15, 4'b0111, 0);
        check("clamp_ready_after", in_ready, 0);
        wait_out(10);
        check("clamp_accepted", accepted, ML);
        check("clamp_latency", latency, ML + 2);
        check("clamp_sum", $signed(out_data), 30720);
        consume();

        // Reset mid-job discards the partial result.
        start_job(4);
        send(8, 4'b0001, 0);
        send(8, 4'b0001, 0);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_in_ready", in_ready, 0);
        check("abort_out_data", $signed(out_data), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("abort_no_valid", out_valid, 0);
        end
        start_job(1);
        send(1, 4'b0000, 0);
        wait_out(10);
        check("after_abort_sum", $signed(out_data), 1);
        consume();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
